note_sequencer: RTL and testbench

Parametrised record/playback note sequencer for the music device top level. It captures up to DEPTH notes from the keyboard input into internal storage and replays them at a fixed tempo. It drives the current note to the tone generator and asserts one-cycle `next_note_en` pulses at each note boundary. Compared with the previous control block, it adds the following:
- configurable depth, note width and tempo;
- internal note storage;
- stop and clear inputs;
- an optional loop mode;
- a tempo divider that restarts on every playback.

---
 rtl/note_sequencer_if.sv | 34 +++
 rtl/note_sequencer.sv | 122 ++++++++++++
 tb/tb_note_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Keyboard/playback control and tone-generator bundle for note_sequencer.
interface note_sequencer_if #(
    parameter int NOTE_W = 4,
    parameter int DEPTH  = 16
) ();
    localparam int CW = $clog2(DEPTH);

    logic              load_n;
    logic              playback;
    logic              stop_n;
    logic              clear_n;
    logic              loop;
    logic [NOTE_W-1:0] note_in;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic              ld_note;
    logic              ld_play;
    logic [CW-1:0]     note_counter;
    logic [CW:0]       notes_recorded;
    logic              full;
    logic              next_note_en;

    modport master (
        output load_n, playback, stop_n, clear_n, loop, note_in,
        input  note_out, note_valid, ld_note, ld_play, note_counter,
               notes_recorded, full, next_note_en
    );

    modport slave (
        input  load_n, playback, stop_n, clear_n, loop, note_in,
        output note_out, note_valid, ld_note, ld_play, note_counter,
               notes_recorded, full, next_note_en
    );
endinterface

// File: rtl/note_sequencer.sv
// Record/playback note sequencer with fixed-tempo divider.
// Define SEQ_LOOP_EN to let the loop input restart the sequence at its end.
module note_sequencer #(
    parameter int DEPTH          = 16,
    parameter int NOTE_W         = 4,
    parameter int TICKS_PER_NOTE = 25000000
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEPTH);
    localparam int TW = $clog2(TICKS_PER_NOTE);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_NOTE - 1);
    localparam logic [CW:0]   FULL_COUNT  = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    state_t            r_state, w_stateNext;
    logic [CW:0]       r_count, w_countNext;
    logic [CW-1:0]     r_noteCounter, w_noteCounterNext;
    logic [TW-1:0]     r_tick, w_tickNext;
    logic [NOTE_W-1:0] r_mem [DEPTH];
    logic              w_memWe;
    logic              w_full;
    logic              w_tickHit;
    logic              w_lastNote;
    logic              w_loopAgain;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_tickHit  = (r_state == PLAY) && (r_tick == '0);
    assign w_lastNote = !({1'b0, r_noteCounter} < (r_count - (CW+1)'(1)));

`ifdef SEQ_LOOP_EN
    assign w_loopAgain = bus.loop;
`else
    assign w_loopAgain = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_noteCounter <= '0;
            r_tick        <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_count       <= w_countNext;
            r_noteCounter <= w_noteCounterNext;
            r_tick        <= w_tickNext;
        end
    end

    // Storage has no reset; it is only read in PLAY, which requires a nonzero count.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[r_count[CW-1:0]] <= bus.note_in;
        end
    end

    always_comb begin
        w_stateNext       = r_state;
        w_countNext       = r_count;
        w_noteCounterNext = r_noteCounter;
        w_tickNext        = r_tick;
        w_memWe           = 1'b0;
        case (r_state)
            IDLE: begin
                w_tickNext        = '0;
                w_noteCounterNext = '0;
                if (!bus.load_n && !w_full) begin
                    w_stateNext = REC;
                end else if (!bus.playback && (r_count != '0)) begin
                    w_stateNext = PLAY;
                    w_tickNext  = TICK_RELOAD;
                end else if (!bus.clear_n) begin
                    w_countNext = '0;
                end
            end
            REC: begin
                w_tickNext = '0;
                if (bus.load_n) begin
                    w_memWe     = 1'b1;
                    w_countNext = r_count + (CW+1)'(1);
                    w_stateNext = IDLE;
                end
            end
            PLAY: begin
                if (!bus.stop_n) begin
                    w_stateNext       = IDLE;
                    w_noteCounterNext = '0;
                    w_tickNext        = '0;
                end else if (w_tickHit) begin
                    w_tickNext = TICK_RELOAD;
                    if (!w_lastNote) begin
                        w_noteCounterNext = r_noteCounter + CW'(1);
                    end else if (w_loopAgain) begin
                        w_noteCounterNext = '0;
                    end else begin
                        w_stateNext       = IDLE;
                        w_noteCounterNext = '0;
                        w_tickNext        = '0;
                    end
                end else begin
                    w_tickNext = r_tick - TW'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.note_out       = (r_state == PLAY) ? r_mem[r_noteCounter] : '0;
    assign bus.note_valid     = (r_state == PLAY);
    assign bus.ld_play        = (r_state == PLAY);
    assign bus.ld_note        = (r_state == REC);
    assign bus.note_counter   = r_noteCounter;
    assign bus.notes_recorded = r_count;
    assign bus.full           = w_full;
    assign bus.next_note_en   = w_tickHit;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed table, corner sequences and random traffic vs. a reference model.
module tb_note_sequencer;
    localparam int DEPTH  = 4;
    localparam int NOTE_W = 4;
    localparam int TPN    = 4;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_sequencer_if #(.NOTE_W(NOTE_W), .DEPTH(DEPTH)) bus ();

    note_sequencer #(
        .DEPTH(DEPTH),
        .NOTE_W(NOTE_W),
        .TICKS_PER_NOTE(TPN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 recording, 2 playing; notes kept as a list.
    int         mMode;
    logic [3:0] mNotes[$];
    int         mIdx;
    int         mElapsed;

    typedef struct {
        logic       ld;
        logic       pb;
        logic [3:0] n;
        logic [3:0] expNote;
        logic       expValid;
        logic       expNext;
        logic       expLdNote;
        logic [2:0] expCount;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        mMode = 0;
        mNotes.delete();
        mIdx = 0;
        mElapsed = 0;
    endfunction

    function automatic void modelStep(input logic ld, pb, st, cl, lp, input logic [3:0] n);
        case (mMode)
            0: begin
                if (!ld && mNotes.size() < DEPTH) mMode = 1;
                else if (!pb && mNotes.size() > 0) begin
                    mMode = 2;
                    mIdx = 0;
                    mElapsed = 0;
                end else if (!cl) mNotes.delete();
            end
            1: begin
                if (ld) begin
                    mNotes.push_back(n);
                    mMode = 0;
                end
            end
            default: begin
                if (!st) begin
                    mMode = 0;
                    mIdx = 0;
                end else if (mElapsed == TPN - 1) begin
                    mElapsed = 0;
                    if (mIdx < mNotes.size() - 1) mIdx++;
                    else if (LOOP_EN && lp) mIdx = 0;
                    else begin
                        mMode = 0;
                        mIdx = 0;
                    end
                end else begin
                    mElapsed++;
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag);
        logic       play;
        logic [3:0] expNote;
        play = (mMode == 2);
        expNote = play ? mNotes[mIdx] : 4'd0;
        check({tag, ".note_out"},       32'(bus.note_out),       32'(expNote));
        check({tag, ".note_valid"},     32'(bus.note_valid),     32'(play));
        check({tag, ".ld_play"},        32'(bus.ld_play),        32'(play));
        check({tag, ".ld_note"},        32'(bus.ld_note),        32'(mMode == 1));
        check({tag, ".note_counter"},   32'(bus.note_counter),   32'(mIdx));
        check({tag, ".notes_recorded"}, 32'(bus.notes_recorded), 32'(mNotes.size()));
        check({tag, ".full"},           32'(bus.full),           32'(mNotes.size() == DEPTH));
        check({tag, ".next_note_en"},   32'(bus.next_note_en),   32'(play && mElapsed == TPN - 1));
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then compare.
    task automatic applyStimulus(input logic ld, pb, st, cl, lp, input logic [3:0] n);
        bus.load_n   = ld;
        bus.playback = pb;
        bus.stop_n   = st;
        bus.clear_n  = cl;
        bus.loop     = lp;
        bus.note_in  = n;
        @(posedge clk);
        modelStep(ld, pb, st, cl, lp, n);
        @(negedge clk);
        checkOutput("model");
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    function automatic vec_t mk(input logic ld, pb, input logic [3:0] n, input logic [3:0] eNote,
                                input logic eValid, eNext, eLd, input logic [2:0] eCnt);
        vec_t v;
        v.ld = ld; v.pb = pb; v.n = n;
        v.expNote = eNote; v.expValid = eValid; v.expNext = eNext;
        v.expLdNote = eLd; v.expCount = eCnt;
        return v;
    endfunction

    initial begin
        bus.load_n = 1'b1; bus.playback = 1'b1; bus.stop_n = 1'b1;
        bus.clear_n = 1'b1; bus.loop = 1'b0; bus.note_in = '0;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_reset");

        // Playback request with nothing recorded is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("empty_play.ld_play", 32'(bus.ld_play), 32'd0);
        idleCycle();

        // Record 3,7,9 then play them back, expectations written out by hand.
        vecs[0]  = mk(0, 1, 3, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 1, 3, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 1, 7, 0, 0, 0, 1, 1);
        vecs[3]  = mk(1, 1, 7, 0, 0, 0, 0, 2);
        vecs[4]  = mk(0, 1, 9, 0, 0, 0, 1, 2);
        vecs[5]  = mk(1, 1, 9, 0, 0, 0, 0, 3);
        vecs[6]  = mk(1, 0, 0, 3, 1, 0, 0, 3);
        vecs[7]  = mk(1, 1, 0, 3, 1, 0, 0, 3);
        vecs[8]  = mk(1, 1, 0, 3, 1, 0, 0, 3);
        vecs[9]  = mk(1, 1, 0, 3, 1, 1, 0, 3);
        vecs[10] = mk(1, 1, 0, 7, 1, 0, 0, 3);
        vecs[11] = mk(1, 1, 0, 7, 1, 0, 0, 3);
        vecs[12] = mk(1, 1, 0, 7, 1, 0, 0, 3);
        vecs[13] = mk(1, 1, 0, 7, 1, 1, 0, 3);
        vecs[14] = mk(1, 1, 0, 9, 1, 0, 0, 3);
        vecs[15] = mk(1, 1, 0, 9, 1, 0, 0, 3);
        vecs[16] = mk(1, 1, 0, 9, 1, 0, 0, 3);
        vecs[17] = mk(1, 1, 0, 9, 1, 1, 0, 3);
        vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].pb, 1'b1, 1'b1, 1'b0, vecs[i].n);
            check($sformatf("vec%0d.note_out", i),       32'(bus.note_out),       32'(vecs[i].expNote));
            check($sformatf("vec%0d.note_valid", i),     32'(bus.note_valid),     32'(vecs[i].expValid));
            check($sformatf("vec%0d.next_note_en", i),   32'(bus.next_note_en),   32'(vecs[i].expNext));
            check($sformatf("vec%0d.ld_note", i),        32'(bus.ld_note),        32'(vecs[i].expLdNote));
            check($sformatf("vec%0d.notes_recorded", i), 32'(bus.notes_recorded), 32'(vecs[i].expCount));
        end

        // Fourth note fills storage; a fifth press must not enter REC.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
        check("fill.full", 32'(bus.full), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15);
        check("overfill.ld_note", 32'(bus.ld_note), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15);
        check("overfill.count", 32'(bus.notes_recorded), 32'd4);

        // Full playback confirms mem[3] kept the fourth note.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 4 * TPN; i++) begin
            if (bus.note_counter == 2'd3) check("mem3.note_out", 32'(bus.note_out), 32'd4);
            idleCycle();
        end
        check("fullplay.end", 32'(bus.ld_play), 32'd0);

        // Stop coinciding with the second tick.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 2 * TPN - 1; i++) idleCycle();
        check("stop.tick2", 32'(bus.next_note_en), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check("stop.ld_play", 32'(bus.ld_play), 32'd0);
        check("stop.note_counter", 32'(bus.note_counter), 32'd0);
        for (int i = 0; i < 2 * TPN; i++) begin
            idleCycle();
            check("stop.no_tick", 32'(bus.next_note_en), 32'd0);
        end

        // Clear is ignored in PLAY, honoured in IDLE.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("clear_play.count", 32'(bus.notes_recorded), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("clear_idle.count", 32'(bus.notes_recorded), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        check("clear2.before", 32'(bus.notes_recorded), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("clear2.after", 32'(bus.notes_recorded), 32'd0);

`ifdef SEQ_LOOP_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 4 * TPN; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
            check("loop.valid", 32'(bus.note_valid), 32'd1);
        end
        for (int i = 0; i < 3 * TPN && mMode == 2; i++) idleCycle();
        check("loop.drop_idle", 32'(bus.ld_play), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) > 2, $urandom_range(0, 9) > 0,
                          $urandom_range(0, 31) > 0, $urandom_range(0, 19) > 0,
                          1'($urandom_range(0, 1)), 4'($urandom));
        end

        // Asynchronous reset in the middle of a played note.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        idleCycle();
        check("pre_reset.note_out", 32'(bus.note_out), 32'd6);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset.note_out", 32'(bus.note_out), 32'd0);
        check("async_reset.note_valid", 32'(bus.note_valid), 32'd0);
        check("async_reset.ld_play", 32'(bus.ld_play), 32'd0);
        check("async_reset.count", 32'(bus.notes_recorded), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        idleCycle();
        check("after_reset.count", 32'(bus.notes_recorded), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
